// File: rtl/uart_rx_capture.sv
// Oversampled UART receiver with a small receive FIFO and sticky error flags.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_capture #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          uart_clk,
    input  logic                          nrst,
    input  logic                          rxd,
    input  logic                          parity_odd,
    input  logic                          err_clr,
    input  logic                          rx_ready,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickFull = TickW'(OVERSAMPLE - 1);
    localparam logic [3:0]       LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LastStop = 4'(STOP_BITS - 1);
    localparam logic [CntW-1:0]  DepthCnt = CntW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic                 rxd_prev_q;
    logic                 rxd_s;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push;
    logic                 frame_set;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q;
    logic                 frame_err_q, overrun_q;
    logic                 full, pop, do_write, overrun_set;

    assign rxd_s = sync_q[1];

    always_ff @(posedge uart_clk) begin
        if (!nrst) begin
            sync_q     <= 2'b11;
            rxd_prev_q <= 1'b1;
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            sync_q     <= {sync_q[0], rxd};
            rxd_prev_q <= rxd_s;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_set;
    logic parity_err_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_set = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                bit_d  = '0;
                if (rxd_prev_q && !rxd_s) state_d = StStart;
            end
            StStart: begin
                if (tick_q == TickHalf) begin
                    tick_d  = '0;
                    state_d = rxd_s ? StIdle : StData;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StData: begin
                if (tick_q == TickFull) begin
                    tick_d  = '0;
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LastData) begin
                        bit_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (tick_q == TickFull) begin
                    tick_d     = '0;
                    // Even parity: data plus parity bit has an even count of ones.
                    parity_set = (^shift_q) ^ rxd_s ^ parity_odd;
                    state_d    = StStop;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (tick_q == TickFull) begin
                    tick_d    = '0;
                    frame_set = !rxd_s;
                    if (bit_q == LastStop) begin
                        bit_d   = '0;
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A pop frees the head slot in the same cycle, so a full FIFO still accepts the push.
    assign full        = (count_q == DepthCnt);
    assign pop         = rx_valid && rx_ready;
    assign do_write    = push && (!full || pop);
    assign overrun_set = push && full && !pop;

    always_ff @(posedge uart_clk) begin
        if (!nrst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (do_write) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_write && !pop)      count_q <= count_q + 1'b1;
            else if (!do_write && pop) count_q <= count_q - 1'b1;
            if (frame_set)             frame_err_q <= 1'b1;
            else if (err_clr)          frame_err_q <= 1'b0;
            if (overrun_set)           overrun_q <= 1'b1;
            else if (err_clr)          overrun_q <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge uart_clk) begin
        if (!nrst)           parity_err_q <= 1'b0;
        else if (parity_set) parity_err_q <= 1'b1;
        else if (err_clr)    parity_err_q <= 1'b0;
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data    = mem_q[rd_ptr_q];
    assign rx_valid   = (count_q != '0);
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed self-checking bench for uart_rx_capture at default parameters.
// Builds with or without UART_RX_PARITY_EN; the parity scenario follows the macro.
module tb_uart_rx_capture;

    localparam int OS = 16;

    logic       uart_clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rxd = 1'b1;
    logic       parity_odd = 1'b0;
    logic       err_clr = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_capture #(
        .DATA_BITS (8),
        .STOP_BITS (1),
        .OVERSAMPLE(OS),
        .FIFO_DEPTH(4)
    ) dut (
        .uart_clk  (uart_clk),
        .nrst      (nrst),
        .rxd       (rxd),
        .parity_odd(parity_odd),
        .err_clr   (err_clr),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .fifo_count(fifo_count)
    );

    always #5 uart_clk = ~uart_clk;

    // Called right after a falling clock edge; returns after one idle bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_lvl, input logic par_bit);
        rxd = 1'b0;
        repeat (OS) @(negedge uart_clk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (OS) @(negedge uart_clk);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par_bit;
        repeat (OS) @(negedge uart_clk);
`else
        if (par_bit === 1'bx) rxd = 1'b1;
`endif
        rxd = stop_lvl;
        repeat (OS) @(negedge uart_clk);
        rxd = 1'b1;
        repeat (OS) @(negedge uart_clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge uart_clk);
        err_clr = 1'b0;
        @(negedge uart_clk);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(negedge uart_clk);
        nrst = 1'b1;
        repeat (4) @(negedge uart_clk);
        n_checks++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
        n_checks++;
        if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", rx_data); end
        n_checks++;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        n_checks++;
        if ({frame_err, parity_err, overrun} !== 3'b000) begin
            n_fail++; $display("FAIL reset_errs got %b exp 000", {frame_err, parity_err, overrun});
        end
    endtask

    task automatic test_single_frame();
        send_frame(8'hA5, 1'b1, 1'b0);
        n_checks++;
        if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", rx_valid); end
        n_checks++;
        if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h exp a5", rx_data); end
        n_checks++;
        if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", fifo_count); end
        n_checks++;
        if ({frame_err, parity_err, overrun} !== 3'b000) begin
            n_fail++; $display("FAIL single_errs got %b exp 000", {frame_err, parity_err, overrun});
        end
        rx_ready = 1'b1;
        @(negedge uart_clk);
        rx_ready = 1'b0;
        n_checks++;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_pop got %0d exp 0", fifo_count); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        n_checks++;
        if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovr_count got %0d exp 4", fifo_count); end
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b exp 1", overrun); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            n_checks++;
            if (rx_data !== exp) begin n_fail++; $display("FAIL ovr_pop%0d got %h exp %h", i, rx_data, exp); end
            rx_ready = 1'b1;
            @(negedge uart_clk);
            rx_ready = 1'b0;
        end
        n_checks++;
        if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_empty got %b exp 0", rx_valid); end
        pulse_clr();
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr got %b exp 0", overrun); end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 1'b0);
        // The final stop sample lands 155 edges after the start bit is driven.
        fork
            send_frame(8'h15, 1'b1, 1'b0);
            begin
                repeat (154) @(negedge uart_clk);
                rx_ready = 1'b1;
                @(negedge uart_clk);
                rx_ready = 1'b0;
            end
        join
        n_checks++;
        if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fullpop_count got %0d exp 4", fifo_count); end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovr got %b exp 0", overrun); end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h12 + 8'(i);
            n_checks++;
            if (rx_data !== exp) begin n_fail++; $display("FAIL fullpop_pop%0d got %h exp %h", i, rx_data, exp); end
            rx_ready = 1'b1;
            @(negedge uart_clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0, 1'b0);
        n_checks++;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set got %b exp 1", frame_err); end
        n_checks++;
        if (rx_data !== 8'h3C || fifo_count !== 3'd1) begin
            n_fail++; $display("FAIL ferr_stored got %h/%0d exp 3c/1", rx_data, fifo_count);
        end
        pulse_clr();
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clr got %b exp 0", frame_err); end
        rx_ready = 1'b1;
        @(negedge uart_clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_false_start();
        rxd = 1'b0;
        repeat (6) @(negedge uart_clk);
        rxd = 1'b1;
        repeat (3 * OS) @(negedge uart_clk);
        n_checks++;
        if (fifo_count !== 3'd0 || rx_valid !== 1'b0) begin
            n_fail++; $display("FAIL false_start got %0d/%b exp 0/0", fifo_count, rx_valid);
        end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL false_start_ferr got %b exp 0", frame_err); end
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0);
        n_checks++;
        if (parity_err !== 1'b1) begin n_fail++; $display("FAIL par_bad got %b exp 1", parity_err); end
        pulse_clr();
        send_frame(8'h07, 1'b1, 1'b1);
        n_checks++;
        if (parity_err !== 1'b0) begin n_fail++; $display("FAIL par_good got %b exp 0", parity_err); end
        n_checks++;
        if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL par_count got %0d exp 2", fifo_count); end
        repeat (2) begin
            rx_ready = 1'b1;
            @(negedge uart_clk);
            rx_ready = 1'b0;
        end
`else
        parity_odd = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        n_checks++;
        if (parity_err !== 1'b0) begin n_fail++; $display("FAIL par_tied got %b exp 0", parity_err); end
        n_checks++;
        if (rx_data !== 8'h07) begin n_fail++; $display("FAIL par_off_data got %h exp 07", rx_data); end
        rx_ready = 1'b1;
        @(negedge uart_clk);
        rx_ready = 1'b0;
        parity_odd = 1'b0;
`endif
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h77, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (50) @(negedge uart_clk);
        nrst = 1'b0;
        repeat (2) @(negedge uart_clk);
        n_checks++;
        if ({rx_valid, frame_err, overrun, fifo_count} !== 6'b000000 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_outs got v%b f%b o%b c%0d d%h exp all 0",
                     rx_valid, frame_err, overrun, fifo_count, rx_data);
        end
        rxd = 1'b1;
        @(negedge uart_clk);
        nrst = 1'b1;
        repeat (OS) @(negedge uart_clk);
        n_checks++;
        if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL midrst_idle got %0d exp 0", fifo_count); end
        send_frame(8'h5A, 1'b1, 1'b0);
        n_checks++;
        if (rx_data !== 8'h5A || fifo_count !== 3'd1) begin
            n_fail++; $display("FAIL midrst_next got %h/%0d exp 5a/1", rx_data, fifo_count);
        end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_ferr got %b exp 0", frame_err); end
    endtask

    initial begin
        @(negedge uart_clk);
        test_reset();
        test_single_frame();
        test_overrun();
        test_full_pop();
        test_frame_err();
        test_false_start();
        test_parity();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_capture.md
UART_RX_CAPTURE -- requirements
Module: uart_rx_capture

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal values 1 or 2.
REQ-003 The block SHALL have parameter OVERSAMPLE, default 16, meaning uart_clk ticks per bit, even, at least 4.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries, power of two, at least 2.
REQ-005 The block SHALL have port uart_clk, input, 1 bit: clock at OVERSAMPLE x baud.
REQ-006 The block SHALL have port nrst, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The block SHALL have port parity_odd, input, 1 bit: 1 selects odd parity, 0 selects even parity.
REQ-009 The block SHALL have port err_clr, input, 1 bit: single-cycle pulse that clears sticky error flags.
REQ-010 The block SHALL have port rx_ready, input, 1 bit: consumer accepts the FIFO head.
REQ-011 The block SHALL have port rx_data, output, DATA_BITS bits: FIFO head data.
REQ-012 The block SHALL have port rx_valid, output, 1 bit: FIFO not empty.
REQ-013 The block SHALL have ports frame_err, parity_err and overrun, output, 1 bit each: sticky error flags.
REQ-014 The block SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: occupancy.

Function
REQ-015 rxd SHALL pass through a 2-flop synchronizer before use; all timing below counts from the synchronized signal.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
- IDLE to START on a synchronized falling edge.
REQ-017 In START, the line SHALL be resampled after OVERSAMPLE/2 ticks.
- Low: go to DATA.
- High: false start, return to IDLE, nothing written.
REQ-018 DATA SHALL sample each bit OVERSAMPLE ticks after the previous sample point, LSB first, DATA_BITS samples.
REQ-019 After DATA, the FSM SHALL enter PARITY when parity is compiled in (REQ-030); otherwise it SHALL enter STOP.
REQ-020 STOP SHALL sample STOP_BITS bits at OVERSAMPLE spacing; any low stop sample sets frame_err.
REQ-021 On the final stop sample, the frame SHALL be pushed to the FIFO regardless of error flags, and the FSM SHALL return to IDLE on the same cycle.
REQ-022 A push into a full FIFO SHALL drop the new frame, set overrun, and leave FIFO contents unchanged.
REQ-023 A pop SHALL occur on any cycle with rx_valid=1 and rx_ready=1; rx_data SHALL be the registered head, valid combinationally from FIFO state.
REQ-024 A simultaneous push and pop SHALL succeed even when full, with fifo_count unchanged and overrun not set.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 If err_clr coincides with an error-setting event, the set SHALL win.

Reset
REQ-027 When nrst=0 at a uart_clk edge, the block SHALL force FSM=IDLE, tick and bit counters=0, FIFO pointers and fifo_count=0, rx_valid=0, rx_data=0, frame_err=parity_err=overrun=0, and synchronizer flops=1.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first frame after release SHALL require a fresh falling edge.

Configuration
REQ-029 The macro UART_RX_PARITY_EN SHALL control parity support.
REQ-030 With UART_RX_PARITY_EN defined:
- PARITY samples one bit OVERSAMPLE ticks after the last data bit.
- The check uses parity_odd; a mismatch sets parity_err.
- The frame length is 1+DATA_BITS+1+STOP_BITS bits.
REQ-031 Without UART_RX_PARITY_EN:
- The PARITY state and the parity_odd logic are absent.
- parity_err is tied to 0.
- The frame length is 1+DATA_BITS+STOP_BITS bits.

Verification
REQ-032 Defaults, no parity: send 0xA5 at 16 ticks/bit with rx_ready=0 -> rx_valid=1, rx_data=0xA5, fifo_count=1, no error flags.
REQ-033 Send 5 frames 0x01..0x05 with rx_ready=0 and FIFO_DEPTH=4 -> fifo_count=4, overrun=1; pops return 0x01..0x04.
REQ-034 Send 0x3C with the stop bit driven low -> frame_err=1, 0x3C stored; err_clr pulse -> frame_err=0.
REQ-035 Parity on, parity_odd=0: send 0x07 with parity bit 0 -> parity_err=1; send 0x07 with parity bit 1 -> no new error.
REQ-036 rxd low for 6 ticks then high -> stays IDLE, fifo_count=0; nrst asserted mid-frame -> all outputs at reset values, the next clean 0x5A is received correctly.
REQ-037 Full FIFO with rx_ready=1 on the push cycle -> fifo_count stays 4, overrun=0.
